puf_majority_voter: RTL
=======================

# puf_majority_voter

Stabilising stage that sits directly downstream of the 16-bit ring-oscillator PUF. It drives the PUF's `enable`/`challenge` inputs and re-runs the same challenge `NUM_SAMPLES` times. It votes each response bit by majority and presents a single 16-bit key with a valid flag. It also guards every PUF run with a timeout so a hung oscillator path cannot stall the key-generation flow.

## Interface
Parameters:
- `NUM_SAMPLES`, default 7: PUF runs per key. Legal values are odd, 1..15; even values are illegal.
- `CNT_W`, default 4: width of the per-bit ones counters. Must satisfy 2^CNT_W > NUM_SAMPLES.
- `TIMEOUT_CYCLES`, default 65535: maximum cycles spent in WAIT_RSP or WAIT_REL before the block aborts.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a key. Sampled only in IDLE, DONE or ERROR.
- `challenge_in` in 5: challenge, latched when `start` is accepted.
- `puf_enable` out 1: drives the PUF `enable` input.
- `puf_challenge` out 5: drives the PUF `challenge` input. Holds the latched value.
- `puf_response` in 16: PUF response.
- `puf_response_valid` in 1: PUF done flag. High while the PUF is in DONE.
- `busy` out 1: high in WAIT_RSP, WAIT_REL and DECIDE.
- `key` out 16: voted key.
- `key_valid` out 1: level signal. High in DONE.
- `error` out 1: level signal. High in ERROR (timeout).
- `unstable_mask` out 16: present only with `PUF_VOTER_MASK_EN`.

## Operation
States and transitions:
- IDLE: `start` → WAIT_RSP.
- WAIT_RSP: `puf_enable`=1. On `puf_response_valid`=1, add each `puf_response[i]` into `ones_cnt[i]`, increment `sample_cnt`, then → WAIT_REL.
- WAIT_REL: `puf_enable`=0. Wait for `puf_response_valid`=0. When it is 0, go → DECIDE if `sample_cnt`==NUM_SAMPLES, otherwise → WAIT_RSP.
- DECIDE: one cycle. `key[i]` = (`ones_cnt[i]` > NUM_SAMPLES/2, integer division). → DONE.
- DONE: `key_valid`=1. `start` → WAIT_RSP.
- ERROR: `error`=1. `start` → WAIT_RSP.

Start acceptance:
- Accepting `start` latches `challenge_in`.
- It clears `ones_cnt`, `sample_cnt`, the timeout counter, `key`, `key_valid`, `error` and `unstable_mask`.
- `start` in any other state is ignored.

Timeout:
- The timeout counter clears on every state entry and increments each cycle in WAIT_RSP and WAIT_REL.
- When it reaches TIMEOUT_CYCLES: go → ERROR, `puf_enable`=0, `key` stays 0, `ones_cnt` is frozen.

Arithmetic:
- Each `ones_cnt[i]` is CNT_W bits and cannot overflow for legal parameters.
- `sample_cnt` is CNT_W bits.

## Timing
Reset values:
- All outputs are 0 at reset: `puf_enable`, `puf_challenge`, `busy`, `key`, `key_valid`, `error`, `unstable_mask`.
- State resets to IDLE.
- Asserting reset mid-operation aborts immediately. The PUF sees `enable` fall on the same edge.

Output timing:
- All outputs are registered.
- `puf_enable` rises the cycle after `start` is accepted.
- Response capture happens on the first cycle `puf_response_valid` is seen high in WAIT_RSP.
- `key` and `key_valid` update together, one cycle after DECIDE is entered.

Latency:
- Key latency = NUM_SAMPLES × (PUF run + release time) + 2 cycles.

Simultaneous or stale events:
- If `puf_response_valid` is already high on entry to WAIT_RSP (stale), it is still captured. WAIT_REL guarantees this cannot occur in normal flow.
- If `start` and timeout expiry coincide, timeout wins.

## Configuration
`PUF_VOTER_MASK_EN` defined:
- `unstable_mask[i]` = 1 when 0 < `ones_cnt[i]` < NUM_SAMPLES, i.e. the bit was not unanimous.
- It is registered in DECIDE alongside `key`.

`PUF_VOTER_MASK_EN` undefined:
- The port and its comparators are absent.
- The voting datapath is otherwise identical.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0 and `puf_enable` never rises.
- NUM_SAMPLES=7, PUF model always returns 16'hA5C3, `start` with `challenge_in`=5'd3 → `puf_challenge`=3, 7 enable pulses, `key`=16'hA5C3, `key_valid`=1, `unstable_mask`=0.
- PUF returns 16'h0001 on 3 runs and 16'h0000 on 4 runs → `key`=16'h0000 and `unstable_mask`=16'h0001. Repeat with 4 runs of 16'h0001 → `key`=16'h0001.
- PUF never asserts valid, TIMEOUT_CYCLES=100 → `error`=1 exactly 100 cycles after entering WAIT_RSP, `puf_enable`=0, `key`=0. A new `start` recovers.
- Assert `rst_n`=0 during the 4th run → outputs immediately 0. After release, a `start` yields the correct key with a fresh vote.
- `start` pulsed while busy with a different challenge → ignored: challenge unchanged and the sample count stays 7.

Source files
------------

// File: rtl/puf_majority_voter_if.sv
// Request/key and PUF handshake signals of the majority voter.
// The unstable_mask member exists only when PUF_VOTER_MASK_EN is defined.
interface puf_majority_voter_if;
    logic        start;
    logic [4:0]  challenge_in;
    logic        puf_enable;
    logic [4:0]  puf_challenge;
    logic [15:0] puf_response;
    logic        puf_response_valid;
    logic        busy;
    logic [15:0] key;
    logic        key_valid;
    logic        error;
`ifdef PUF_VOTER_MASK_EN
    logic [15:0] unstable_mask;

    modport master (
        output start, challenge_in, puf_response, puf_response_valid,
        input  puf_enable, puf_challenge, busy, key, key_valid, error, unstable_mask
    );
    modport slave (
        input  start, challenge_in, puf_response, puf_response_valid,
        output puf_enable, puf_challenge, busy, key, key_valid, error, unstable_mask
    );
`else
    modport master (
        output start, challenge_in, puf_response, puf_response_valid,
        input  puf_enable, puf_challenge, busy, key, key_valid, error
    );
    modport slave (
        input  start, challenge_in, puf_response, puf_response_valid,
        output puf_enable, puf_challenge, busy, key, key_valid, error
    );
`endif
endinterface

// File: rtl/puf_majority_voter.sv
// Re-runs one PUF challenge NUM_SAMPLES times and majority-votes each response bit into a key.
// Optional macro PUF_VOTER_MASK_EN adds unstable_mask (bits whose samples were not unanimous).
module puf_majority_voter #(
    parameter int NUM_SAMPLES    = 7,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    puf_majority_voter_if.slave  bus
);
    localparam int NBITS = 16;
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(NUM_SAMPLES / 2);

    if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES < 1 || NUM_SAMPLES > 15) begin : g_bad_samples
        $error("puf_majority_voter: NUM_SAMPLES must be odd and within 1..15");
    end
    if ((1 << CNT_W) <= NUM_SAMPLES) begin : g_bad_cnt_w
        $error("puf_majority_voter: CNT_W too narrow for NUM_SAMPLES");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RSP, S_WAIT_REL, S_DECIDE, S_DONE, S_ERROR
    } state_t;

    state_t             r_state;
    logic [4:0]         r_challenge;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_puf_enable;
    logic               r_busy;
    logic [NBITS-1:0]   r_key;
    logic               r_key_valid;
    logic               r_error;
    logic [NBITS-1:0]   w_vote;
    logic               w_accept;
    logic               w_capture;

    assign w_accept  = bus.start &&
                       (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_capture = (r_state == S_WAIT_RSP) && bus.puf_response_valid;

`ifdef PUF_VOTER_MASK_EN
    logic [NBITS-1:0] r_unstable_mask;
    logic [NBITS-1:0] w_unstable;
    assign bus.unstable_mask = r_unstable_mask;
`endif

    // One ones-counter per response bit; the vote is a plain threshold on it.
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
        logic [CNT_W-1:0] r_ones_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ones_cnt <= '0;
            end else if (w_accept) begin
                r_ones_cnt <= '0;
            end else if (w_capture) begin
                r_ones_cnt <= r_ones_cnt + CNT_W'(bus.puf_response[gi]);
            end
        end

        assign w_vote[gi] = (r_ones_cnt > HALF_C);
`ifdef PUF_VOTER_MASK_EN
        assign w_unstable[gi] = (r_ones_cnt != '0) && (r_ones_cnt < SAMPLES_C);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_challenge  <= '0;
            r_sample_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_puf_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_error      <= 1'b0;
`ifdef PUF_VOTER_MASK_EN
            r_unstable_mask <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        r_state      <= S_WAIT_RSP;
                        r_challenge  <= bus.challenge_in;
                        r_sample_cnt <= '0;
                        r_tmo_cnt    <= '0;
                        r_puf_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_key        <= '0;
                        r_key_valid  <= 1'b0;
                        r_error      <= 1'b0;
`ifdef PUF_VOTER_MASK_EN
                        r_unstable_mask <= '0;
`endif
                    end
                end
                S_WAIT_RSP: begin
                    if (bus.puf_response_valid) begin
                        r_state      <= S_WAIT_REL;
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        r_tmo_cnt    <= '0;
                        r_puf_enable <= 1'b0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state      <= S_ERROR;
                        r_puf_enable <= 1'b0;
                        r_busy       <= 1'b0;
                        r_error      <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    // Waiting for release keeps a held valid from being counted twice.
                    if (!bus.puf_response_valid) begin
                        r_tmo_cnt <= '0;
                        if (r_sample_cnt == SAMPLES_C) begin
                            r_state <= S_DECIDE;
                        end else begin
                            r_state      <= S_WAIT_RSP;
                            r_puf_enable <= 1'b1;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_state <= S_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_state     <= S_DONE;
                    r_key       <= w_vote;
                    r_key_valid <= 1'b1;
                    r_busy      <= 1'b0;
`ifdef PUF_VOTER_MASK_EN
                    r_unstable_mask <= w_unstable;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.puf_enable    = r_puf_enable;
    assign bus.puf_challenge = r_challenge;
    assign bus.busy          = r_busy;
    assign bus.key           = r_key;
    assign bus.key_valid     = r_key_valid;
    assign bus.error         = r_error;
endmodule
